icache_controller: RTL

Direct-mapped instruction cache that sits between the pipeline fetch stage and the backing instruction memory bus. It answers fetch reads, and on a miss it drives `o_p_waitrequest`, the stall signal the fetch side already honours. It then refills the whole line from memory with single-word reads before releasing the stall. The fetch side sees combinational hit data and, during reset, a zero instruction word.

---
 rtl/icache_controller.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache: combinational hit path, whole-line refill with single-word reads.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module icache_controller #(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] p_addr,
    input  logic        p_read,
    output logic [31:0] p_readdata,
    output logic        o_p_waitrequest,
    input  logic        flush,
    output logic [31:0] m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int WB = $clog2(WORDS_PER_LINE);
    localparam int IB = $clog2(LINES);
    localparam int OB = WB + 2;
    localparam int TB = 32 - OB - IB;
    localparam logic [WB-1:0] LAST_WORD = WB'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FILL = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LINES-1:0] r_valid;
    logic [TB-1:0]    r_tag  [LINES];
    logic [31:0]      r_data [LINES][WORDS_PER_LINE];
    logic [31-OB:0]   r_base;
    logic [WB-1:0]    r_cnt;
    logic [WB-1:0]    w_cnt_nxt;
    logic [WB-1:0]    w_cnt_inc;
    logic             r_flush_pend;
    logic             r_m_read;
    logic             w_m_read_nxt;
    logic [31:0]      r_m_address;
    logic [31:0]      w_m_address_nxt;
    logic [31:0]      r_last_data;

    logic [WB-1:0]    w_offset;
    logic [IB-1:0]    w_index;
    logic [TB-1:0]    w_tag;
    logic [IB-1:0]    w_fill_index;
    logic [31:0]      w_hit_data;
    logic             w_hit;
    logic             w_miss;
    logic             w_unused;

    assign w_offset     = p_addr[OB-1:2];
    assign w_index      = p_addr[OB+IB-1:OB];
    assign w_tag        = p_addr[31:OB+IB];
    assign w_fill_index = r_base[IB-1:0];
    assign w_hit_data   = r_data[w_index][w_offset];
    assign w_cnt_inc    = r_cnt + WB'(1);
    assign w_hit        = p_read & (r_state == S_IDLE) & r_valid[w_index] & (r_tag[w_index] == w_tag);
    assign w_miss       = p_read & (r_state == S_IDLE) & ~w_hit;
    assign w_unused     = ^p_addr[1:0];

    // Refill sequencer: next state, word counter and the next registered bus request.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_m_read_nxt    = r_m_read;
        w_m_address_nxt = r_m_address;
        case (r_state)
            S_IDLE: begin
                if (w_miss) begin
                    w_state_nxt     = S_REQ;
                    w_cnt_nxt       = {WB{1'b0}};
                    w_m_read_nxt    = 1'b1;
                    w_m_address_nxt = {p_addr[31:OB], {OB{1'b0}}};
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REQ: begin
                if (!m_waitrequest) begin
                    w_state_nxt  = S_WAIT;
                    w_m_read_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_WAIT: begin
                if (m_readdatavalid) begin
                    if (r_cnt == LAST_WORD) begin
                        w_state_nxt = S_FILL;
                    end else begin
                        w_state_nxt     = S_REQ;
                        w_cnt_nxt       = w_cnt_inc;
                        w_m_read_nxt    = 1'b1;
                        w_m_address_nxt = {r_base, w_cnt_inc, 2'b00};
                    end
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_FILL: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_m_read_nxt = 1'b0;
            end
        endcase
    end

    // Control state: FSM, valid bits, flush-pending, bus request registers and held fetch data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_valid      <= {LINES{1'b0}};
            r_cnt        <= {WB{1'b0}};
            r_flush_pend <= 1'b0;
            r_m_read     <= 1'b0;
            r_m_address  <= 32'd0;
            r_last_data  <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_m_read    <= w_m_read_nxt;
            r_m_address <= w_m_address_nxt;
            if (w_hit) begin
                r_last_data <= w_hit_data;
            end
            // A flush in the FILL cycle itself must also keep the line invalid.
            if (flush) begin
                r_valid <= {LINES{1'b0}};
            end else if ((r_state == S_FILL) && !r_flush_pend) begin
                r_valid[w_fill_index] <= 1'b1;
            end
            if (r_state == S_FILL) begin
                r_flush_pend <= 1'b0;
            end else if (flush && (r_state != S_IDLE)) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    // Line storage: base latch, refill data words and tag; deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_miss) begin
            r_base <= p_addr[31:OB];
        end
        if (rst && (r_state == S_WAIT) && m_readdatavalid) begin
            r_data[w_fill_index][r_cnt] <= m_readdata;
        end
        if (rst && (r_state == S_FILL)) begin
            r_tag[w_fill_index] <= r_base[31-OB:IB];
        end
    end

    // Fetch and bus outputs, forced to their reset values while rst is low.
    always_comb begin
        if (!rst) begin
            p_readdata      = 32'd0;
            o_p_waitrequest = 1'b1;
            m_read          = 1'b0;
            m_address       = 32'd0;
        end else begin
            p_readdata      = w_hit ? w_hit_data : r_last_data;
            o_p_waitrequest = (r_state != S_IDLE) | w_miss;
            m_read          = r_m_read;
            m_address       = r_m_address;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Hit and miss statistics; flush leaves them untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            if (w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif
endmodule
